// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition-code enum and NZCV bit positions
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_if.sv
// rtl/cond_if.sv - decoder requests in, gated commit strobes and status out
interface cond_if;

  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        RegW;
  logic        MemW;
  logic        NoWrite;
  logic        Stall;
  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic        CondEx;
  logic        Undef;
  logic [3:0]  Flags;
  logic [15:0] SkipCount;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    input  PCSrc, RegWrite, MemWrite, CondEx, Undef, Flags, SkipCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    output PCSrc, RegWrite, MemWrite, CondEx, Undef, Flags, SkipCount
  );

endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates an ARM condition field against registered flags
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx,
  output logic       Undef
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    Undef  = 1'b0;
    case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: Undef  = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register, commit gating and skipped-instruction counter
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic  clk,
  input  logic  reset,
  cond_if.slave bus
);

  logic [3:0]  flags_q;
  logic [15:0] skip_q;
  logic        cond_ex;
  logic        undef;
  logic        commit;
  logic        skip_inc;

  cond_check u_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex),
    .Undef  (undef)
  );

  assign commit   = cond_ex & ~bus.Stall;
  // undef already forces cond_ex low, so it must be excluded explicitly here
  assign skip_inc = ~bus.Stall & ~cond_ex & ~undef & (skip_q != 16'hFFFF);

  assign bus.PCSrc     = bus.PCS & commit;
  assign bus.RegWrite  = bus.RegW & ~bus.NoWrite & commit;
  assign bus.MemWrite  = bus.MemW & commit;
  assign bus.CondEx    = cond_ex;
  assign bus.Undef     = undef;
  assign bus.Flags     = flags_q;
  assign bus.SkipCount = skip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
      skip_q  <= 16'd0;
    end else begin
      if (commit && bus.FlagW[1]) begin
        flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (commit && bus.FlagW[0]) begin
        flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
      if (skip_inc) begin
        skip_q <= skip_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed and randomized checks of cond_unit against a reference model
module tb_cond_unit;
  import cond_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [3:0] m_flags;
  int         m_skip;
  logic       obs_condex, obs_undef, obs_pcsrc, obs_regwrite, obs_memwrite;

  cond_if bus ();

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM-style evaluation: Cond[3:1] picks a base test, Cond[0] inverts it
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b0;
    return base ^ cond[0];
  endfunction

  task automatic drive(input logic [3:0] cond, input logic [3:0] aluf, input logic [1:0] flagw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nowrite, input logic stall);
    bus.Cond = cond; bus.ALUFlags = aluf; bus.FlagW = flagw; bus.PCS = pcs;
    bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nowrite; bus.Stall = stall;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input logic [3:0] cond, input logic [3:0] aluf, input logic [1:0] flagw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nowrite, input logic stall);
    logic ex, und;
    drive(cond, aluf, flagw, pcs, regw, memw, nowrite, stall);
    #2;
    ex  = ref_cond(cond, m_flags);
    und = (cond == 4'hF);
    obs_condex = bus.CondEx; obs_undef = bus.Undef; obs_pcsrc = bus.PCSrc;
    obs_regwrite = bus.RegWrite; obs_memwrite = bus.MemWrite;
    chk("condex",   {15'd0, bus.CondEx},   {15'd0, ex});
    chk("undef",    {15'd0, bus.Undef},    {15'd0, und});
    chk("pcsrc",    {15'd0, bus.PCSrc},    {15'd0, pcs && ex && !stall});
    chk("regwrite", {15'd0, bus.RegWrite}, {15'd0, regw && ex && !nowrite && !stall});
    chk("memwrite", {15'd0, bus.MemWrite}, {15'd0, memw && ex && !stall});
    chk("flags_pre", {12'd0, bus.Flags}, {12'd0, m_flags});
    @(posedge clk);
    #1;
    if (!stall && ex) begin
      if (flagw[1]) m_flags[3:2] = aluf[3:2];
      if (flagw[0]) m_flags[1:0] = aluf[1:0];
    end
    if (!stall && !ex && !und) m_skip = (m_skip >= 65535) ? 65535 : m_skip + 1;
    chk("flags", {12'd0, bus.Flags}, {12'd0, m_flags});
    chk("skip",  bus.SkipCount, m_skip[15:0]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_flags = 4'b0000;
    m_skip  = 0;
    chk("rst_flags", {12'd0, bus.Flags}, 16'h0000);
    chk("rst_skip",  bus.SkipCount, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] skip_before;
    checks = 0;
    errors = 0;
    m_flags = 4'b0000;
    m_skip  = 0;

    // reset with EQ against zero flags
    reset = 1'b1;
    drive(EQ, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("r_condex", {15'd0, bus.CondEx}, 16'h0000);
    chk("r_flags",  {12'd0, bus.Flags},  16'h0000);
    chk("r_skip",   bus.SkipCount,       16'h0000);
    @(negedge clk);
    reset = 1'b0;
    apply(EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    chk("first_edge_skip", bus.SkipCount, 16'h0001);

    // flag write then dependent condition next cycle
    apply(AL, 4'b0110, 2'b11, 0, 0, 0, 0, 0);
    chk("flags_0110", {12'd0, bus.Flags}, 16'h0006);
    apply(EQ, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    chk("eq_condex", {15'd0, obs_condex}, 16'h0001);
    chk("eq_regwrite", {15'd0, obs_regwrite}, 16'h0001);

    // GE fails with N!=V, passes with N==V
    apply(AL, 4'b1000, 2'b11, 0, 0, 0, 0, 0);
    apply(GE, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
    chk("ge_fail_condex", {15'd0, obs_condex}, 16'h0000);
    chk("ge_fail_memwrite", {15'd0, obs_memwrite}, 16'h0000);
    apply(AL, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
    apply(GE, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
    chk("ge_pass_condex", {15'd0, obs_condex}, 16'h0001);
    chk("ge_pass_memwrite", {15'd0, obs_memwrite}, 16'h0001);

    // reset mid-cycle with a flag write pending: async clear and write discarded
    drive(AL, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_flags", {12'd0, bus.Flags}, 16'h0000);
    chk("async_skip",  bus.SkipCount,      16'h0000);
    @(posedge clk);
    #1;
    chk("held_in_reset", {12'd0, bus.Flags}, 16'h0000);
    m_flags = 4'b0000;
    m_skip  = 0;
    @(negedge clk);
    reset = 1'b0;

    // partial flag write, NoWrite suppression
    apply(AL, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
    chk("flags_nz_only", {12'd0, bus.Flags}, 16'h000C);
    apply(AL, 4'b0000, 2'b00, 0, 1, 0, 1, 0);
    chk("nowrite_regwrite", {15'd0, obs_regwrite}, 16'h0000);

    // stall blocks commits and flag writes; NV never counts
    apply(AL, 4'b1111, 2'b11, 1, 0, 0, 0, 1);
    chk("stall_pcsrc", {15'd0, obs_pcsrc}, 16'h0000);
    chk("stall_flags", {12'd0, bus.Flags}, 16'h000C);
    skip_before = bus.SkipCount;
    apply(NV, 4'b0011, 2'b11, 0, 0, 0, 0, 0);
    chk("nv_undef", {15'd0, obs_undef}, 16'h0001);
    chk("nv_skip",  bus.SkipCount, skip_before);
    chk("nv_flags", {12'd0, bus.Flags}, 16'h000C);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    // saturation of the skip counter
    do_reset();
    drive(EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("preload_skip", bus.SkipCount, 16'hFFFE);
    m_skip = 16'hFFFE;
    @(negedge clk);
    apply(EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    apply(EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    chk("sat_skip", bus.SkipCount, 16'hFFFF);
    apply(NE, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    apply(EQ, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    chk("sat_hold", bus.SkipCount, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: RESET_FLAGS, default 4'b0000, NZCV value loaded into the flag register on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Cond  input  4  ARM condition field of the current instruction (Instr[31:28]).
REQ-005 ALUFlags  input  4  NZCV from the ALU for the current instruction, {N,Z,C,V} = bits [3:0] MSB-first.
REQ-006 FlagW  input  2  flag-write enables: bit1 -> N,Z; bit0 -> C,V.
REQ-007 PCS, RegW, MemW, NoWrite  input  1 each  decoder requests: PC write, register write, memory write, suppress register write (CMP/CMN/TST/TEQ).
REQ-008 Stall  input  1  holds all state and suppresses all commits this cycle.
REQ-009 PCSrc, RegWrite, MemWrite  output  1 each  gated commit strobes.
REQ-010 CondEx  output  1  condition passed for current instruction.
REQ-011 Undef  output  1  Cond == 4'b1111 seen this cycle.
REQ-012 Flags  output  4  current flag register contents {N,Z,C,V}.
REQ-013 SkipCount  output  16  saturating count of condition-failed instructions.

Function
REQ-014 CondEx SHALL be combinational from Cond and the registered Flags (not ALUFlags); zero added latency.
REQ-015 Condition table: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
REQ-016 Cond 1111: CondEx = 0, Undef = 1; otherwise Undef = 0.
REQ-017 PCSrc = PCS & CondEx & ~Stall.
REQ-018 RegWrite = RegW & CondEx & ~NoWrite & ~Stall.
REQ-019 MemWrite = MemW & CondEx & ~Stall.
REQ-020 On rising edge with ~Stall & CondEx & FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
REQ-021 On rising edge with ~Stall & CondEx & FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
REQ-022 Flag bits not selected by FlagW, or when CondEx = 0, SHALL hold.
REQ-023 New flags visible on Flags/CondEx the cycle after the write (one-cycle flag latency); same-cycle Cond evaluates old flags.
REQ-024 SkipCount increments by 1 on rising edge when ~Stall & ~CondEx & Cond != 4'b1111; saturates at 16'hFFFF (no wrap).
REQ-025 Stall = 1: Flags and SkipCount hold; all commit strobes 0; CondEx and Undef still reflect inputs.
REQ-026 Undef cycles SHALL not update flags and SHALL not increment SkipCount.

Reset
REQ-027 reset asserted: Flags <= RESET_FLAGS and SkipCount <= 0 immediately, independent of clk.
REQ-028 reset asserted mid-operation SHALL discard any pending flag write on that edge; outputs derive from reset state until release.
REQ-029 First rising edge after reset deassertion SHALL perform normal updates.

Structure
REQ-030 Shared package cond_pkg SHALL hold the condition-code enum (EQ..AL, NV=4'b1111) and flag bit-index constants (N=3, Z=2, C=1, V=0).
REQ-031 One sub-module cond_check (combinational Cond+Flags -> CondEx, Undef); flag register, counter and gating live in cond_unit.

Verification
REQ-032 Reset, RESET_FLAGS=0: Cond=0000 (EQ) -> CondEx=0, Flags=0000, SkipCount=0; release, one edge -> SkipCount=1.
REQ-033 Cond=1110, FlagW=11, ALUFlags=0110 -> edge -> Flags=0110; next cycle Cond=0000, RegW=1 -> CondEx=1, RegWrite=1.
REQ-034 Flags=1000, Cond=1010 (GE) -> CondEx=0, MemW=1 -> MemWrite=0; Flags=1001 -> CondEx=1, MemWrite=1.
REQ-035 Cond=1110, FlagW=10, ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V held); Cond=1110, RegW=1, NoWrite=1 -> RegWrite=0.
REQ-036 Stall=1, Cond=1110, FlagW=11, PCS=1, ALUFlags=1111 -> PCSrc=0, Flags unchanged; Cond=1111 -> Undef=1, SkipCount unchanged.
REQ-037 Preload SkipCount to 16'hFFFE via 2^16-2 failed cycles; two more failed cycles -> SkipCount=16'hFFFF, holds.
